// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin, burst-limited sharing of one data memory port between CPU and external requester
module data_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_EXT} state_t;
  state_t state_q, state_d;
  logic last_ext_q, last_ext_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ext_rdata_q, ext_rdata_d;
  logic cpu_rvalid_q, cpu_rvalid_d, ext_rvalid_q, ext_rvalid_d;
  logic cpu_win, repeat_gnt, other_req, any_gnt;
  // owner, round-robin pointer, burst counter and read-return registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_ext_q   <= 1'b1;
      burst_q      <= '0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_ext_q   <= last_ext_d;
      burst_q      <= burst_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end
  // grant decision, next state, memory mux and read capture; grants are held off while reset is low
  always_comb begin
    cpu_win      = (state_q == IDLE) ? last_ext_q :
                   (state_q == OWN_CPU) ? (burst_q < MAXB) : (burst_q == MAXB);
    cpu_gnt      = reset & cpu_req & (~ext_req | cpu_win);
    ext_gnt      = reset & ext_req & ~cpu_gnt;
    any_gnt      = cpu_gnt | ext_gnt;
    cpu_stall    = reset & cpu_req & ~cpu_gnt;
    state_d      = cpu_gnt ? OWN_CPU : ext_gnt ? OWN_EXT : IDLE;
    last_ext_d   = any_gnt ? ext_gnt : last_ext_q;
    repeat_gnt   = (cpu_gnt & (state_q == OWN_CPU)) | (ext_gnt & (state_q == OWN_EXT));
    other_req    = cpu_gnt ? ext_req : cpu_req;
    burst_d      = !any_gnt ? burst_q :
                   !repeat_gnt ? CW'(1) :
                   (other_req && burst_q != MAXB) ? burst_q + CW'(1) : burst_q;
    mem_addr     = cpu_gnt ? cpu_addr : ext_gnt ? ext_addr : '0;
    mem_wdata    = cpu_gnt ? cpu_wdata : ext_gnt ? ext_wdata : '0;
    mem_we       = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    ext_rvalid_d = ext_gnt & ~ext_we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
    ext_rdata_d  = ext_rvalid_d ? mem_rdata : ext_rdata_q;
  end
  assign cpu_rdata  = cpu_rdata_q;
  assign ext_rdata  = ext_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scoreboard bench for data_mem_arbiter with a behavioural data memory
module tb_data_mem_arbiter;
  logic clock, reset;
  logic cpu_req, cpu_we, ext_req, ext_we;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_we;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:65535];
  int checks = 0, errors = 0;
  typedef struct {
    logic cg, eg, we, st;
    logic [15:0] a, d;
  } rec_t;
  rec_t gq[$];
  logic [15:0] cq[$], eq[$];

  data_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (gq.size() > 0) begin
      rec_t r;
      r = gq.pop_front();
      chk("cpu_gnt", 16'(cpu_gnt), 16'(r.cg));
      chk("ext_gnt", 16'(ext_gnt), 16'(r.eg));
      chk("mem_we", 16'(mem_we), 16'(r.we));
      chk("cpu_stall", 16'(cpu_stall), 16'(r.st));
      chk("mem_addr", mem_addr, r.a);
      chk("mem_wdata", mem_wdata, r.d);
    end
    if (cpu_rvalid) begin
      if (cq.size() > 0) chk("cpu_rdata", cpu_rdata, cq.pop_front());
      else begin
        checks++; errors++;
        $display("FAIL cpu_rvalid: got 1 expected 0 (rdata %h)", cpu_rdata);
      end
    end
    if (ext_rvalid) begin
      if (eq.size() > 0) chk("ext_rdata", ext_rdata, eq.pop_front());
      else begin
        checks++; errors++;
        $display("FAIL ext_rvalid: got 1 expected 0 (rdata %h)", ext_rdata);
      end
    end
  end

  task automatic step(input logic cr, cw, input logic [15:0] ca, cd,
                      input logic er, ew, input logic [15:0] ea, ed,
                      input logic xc, xe, input logic [15:0] xrd);
    rec_t r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    r.cg = xc; r.eg = xe;
    r.we = (xc & cw) | (xe & ew);
    r.st = cr & ~xc & reset;
    r.a = xc ? ca : xe ? ea : 16'h0;
    r.d = xc ? cd : xe ? ed : 16'h0;
    gq.push_back(r);
    if (xc && !cw) cq.push_back(xrd);
    if (xe && !ew) eq.push_back(xrd);
    @(posedge clock); #1;
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
  endtask

  initial begin
    logic [9:0] pat;
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA000;
    #1;
    // reset held: both requesting, nothing granted, writes must not land
    step(1, 0, 16'h20, 16'h0, 1, 0, 16'h30, 16'h0, 0, 0, 16'h0);
    step(1, 1, 16'h20, 16'hDEAD, 1, 1, 16'h30, 16'hBEEF, 0, 0, 16'h0);
    chk("rst_cpu_rvalid", 16'(cpu_rvalid), 16'h0);
    chk("rst_ext_rvalid", 16'(ext_rvalid), 16'h0);
    chk("rst_cpu_rdata", cpu_rdata, 16'h0);
    chk("rst_ext_rdata", ext_rdata, 16'h0);
    reset = 1'b1;
    // continuous contention: C,C,C,C,E,E,E,E,C,C
    pat = 10'b1100001111;
    for (int i = 0; i < 10; i++)
      step(1, 0, 16'h20, 16'h0, 1, 0, 16'h30, 16'h0, pat[i], !pat[i], pat[i] ? 16'hA020 : 16'hA030);
    idle();
    // CPU write then read back
    step(1, 1, 16'h0005, 16'h1234, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    step(1, 0, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h1234);
    idle();
    // EXT alone for 10 cycles must not build up burst count
    step(0, 0, 16'h0, 16'h0, 1, 1, 16'h40, 16'hBEEF, 0, 1, 16'h0);
    for (int i = 0; i < 9; i++)
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h40, 16'h0, 0, 1, 16'hBEEF);
    for (int i = 0; i < 4; i++)
      step(1, 0, 16'h0005, 16'h0, 1, 0, 16'h40, 16'h0, i == 3, i < 3, i == 3 ? 16'h1234 : 16'hBEEF);
    idle();
    // round-robin across idle gaps
    step(0, 0, 16'h0, 16'h0, 1, 0, 16'h11, 16'h0, 0, 1, 16'hA011);
    idle();
    step(1, 0, 16'h20, 16'h0, 1, 0, 16'h30, 16'h0, 1, 0, 16'hA020);
    idle();
    step(1, 0, 16'h20, 16'h0, 1, 0, 16'h30, 16'h0, 0, 1, 16'hA030);
    idle();
    // EXT read aborted by a reset pulse before its closing edge
    begin
      rec_t r;
      ext_req = 1; ext_we = 0; ext_addr = 16'h10; ext_wdata = 16'h0;
      r.cg = 0; r.eg = 1; r.we = 0; r.st = 0; r.a = 16'h10; r.d = 16'h0;
      gq.push_back(r);
      @(negedge clock); #1;
      reset = 1'b0; ext_req = 0;
      #2 reset = 1'b1;
      @(posedge clock); #1;
      chk("abort_ext_rvalid", 16'(ext_rvalid), 16'h0);
      chk("abort_ext_rdata", ext_rdata, 16'h0);
    end
    step(1, 0, 16'h20, 16'h0, 1, 0, 16'h30, 16'h0, 1, 0, 16'hA020);
    idle();
    idle();
    chk("cpu_reads_left", 16'(cq.size()), 16'h0);
    chk("ext_reads_left", 16'(eq.size()), 16'h0);
    chk("grant_recs_left", 16'(gq.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
